// File: rtl/down_timer.sv
// down_timer: N-bit loadable down-counter with start/stop/pause,
// optional auto-reload and a single-cycle terminal-count strobe.
// Q counts L, L-1, ..., 0; the cycle spent at 0 in RUN is the terminal
// cycle (tc), so one period is L+1 cycles.
module down_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  output logic [N-1:0] Q,
  output logic         busy,
  output logic         tc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] r_current;
  logic [N-1:0] r_reload;

  // Count value as seen by an IDLE start, including a same-cycle load.
  logic [N-1:0] q_eff;
  logic         at_zero;

  assign q_eff   = load ? load_val : r_current;
  assign at_zero = (r_current == '0);

  // State, count and reload registers; stop in RUN outranks both the
  // decrement and terminal handling.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      r_current <= '0;
      r_reload  <= '0;
    end else begin
      if (load) r_reload <= load_val;
      case (state)
        IDLE: begin
          if (load) r_current <= load_val;
          if (start && (q_eff != '0)) state <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= PAUSE;
          end else if (!at_zero) begin
            r_current <= r_current - N'(1);
          end else if (auto_reload && (r_reload != '0)) begin
            // r_reload here is the pre-load value: a load in this cycle
            // only takes effect at the following reload.
            r_current <= r_reload;
          end else begin
            state <= IDLE;
          end
        end
        PAUSE: begin
          if (load) r_current <= load_val;
          if (stop)       state <= IDLE;
          else if (start) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Q    = r_current;
  assign busy = (state == RUN);
  // Combinational only through stop; everything else is registered.
  assign tc   = (state == RUN) && at_zero && !stop;

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed stimulus for down_timer (N=4) with
// hand-computed expectations checked by immediate assertions.
module tb_down_timer;

  localparam int N = 4;

  logic         clk;
  logic         n_reset;
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [N-1:0] Q;
  logic         busy;
  logic         tc;

  int errors = 0;
  int checks = 0;
  int ntc;
  int cnt;
  int expq;

  down_timer #(.N(N)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .Q           (Q),
    .busy        (busy),
    .tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call are sampled at this edge;
  // single-cycle pulses are dropped afterwards, outputs settle by +2.
  task automatic step();
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    #1;
  endtask

  initial begin
    n_reset = 1'b1; load = 1'b0; load_val = '0;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0;

    // Reset asserted between edges, then held for 3 cycles
    #7 n_reset = 1'b0;
    #1;
    chk("rst_q", Q, 0); chk("rst_busy", busy, 0); chk("rst_tc", tc, 0);
    repeat (3) step();
    chk("rst_hold_q", Q, 0); chk("rst_hold_busy", busy, 0); chk("rst_hold_tc", tc, 0);
    n_reset = 1'b1;

    // Start with Q = 0 in IDLE is ignored
    start = 1'b1; step();
    chk("zero_start_busy", busy, 0); chk("zero_start_tc", tc, 0);

    // One-shot, load 5
    load = 1'b1; load_val = 4'd5; step();
    chk("os_load_q", Q, 5); chk("os_load_busy", busy, 0);
    start = 1'b1; step();
    for (int e = 5; e >= 0; e--) begin
      chk("os_q", Q, e); chk("os_tc", tc, (e == 0)); chk("os_busy", busy, 1);
      step();
    end
    chk("os_end_busy", busy, 0); chk("os_end_q", Q, 0); chk("os_end_tc", tc, 0);
    step();
    chk("os_hold_q", Q, 0); chk("os_hold_busy", busy, 0);

    // Auto-reload, load 3, 12 cycles
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1; step();
    start = 1'b1; step();
    ntc = 0;
    for (int i = 0; i < 12; i++) begin
      expq = 3 - (i % 4);
      chk("ar_q", Q, expq); chk("ar_tc", tc, (expq == 0)); chk("ar_busy", busy, 1);
      if (tc) ntc++;
      step();
    end
    chk("ar_tc_count", ntc, 3);
    // Load 7 mid-period: current period still ends at 0, next starts at 7
    chk("ar_ld_q3", Q, 3);
    load = 1'b1; load_val = 4'd7; step();
    chk("ar_ld_q2", Q, 2); step();
    chk("ar_ld_q1", Q, 1); step();
    chk("ar_ld_q0", Q, 0); chk("ar_ld_tc", tc, 1); step();
    chk("ar_ld_q7", Q, 7); chk("ar_ld_busy", busy, 1); step();
    chk("ar_ld_q6", Q, 6);
    stop = 1'b1; step();
    stop = 1'b1; step();
    chk("ar_abort_busy", busy, 0); chk("ar_abort_q", Q, 6);
    auto_reload = 1'b0;

    // Pause at 6, hold 4 cycles, resume to 0
    load = 1'b1; load_val = 4'd9; step();
    start = 1'b1; step();
    chk("pr_q9", Q, 9);
    step(); step(); step();
    chk("pr_q6", Q, 6);
    stop = 1'b1; #1;
    chk("pr_stop_tc", tc, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("pr_hold_q", Q, 6); chk("pr_hold_busy", busy, 0); chk("pr_hold_tc", tc, 0);
      step();
    end
    start = 1'b1; step();
    ntc = 0;
    for (int e = 6; e >= 0; e--) begin
      chk("pr_res_q", Q, e); chk("pr_res_busy", busy, 1);
      if (tc) ntc++;
      step();
    end
    chk("pr_tc_once", ntc, 1); chk("pr_done_busy", busy, 0);

    // Abort from PAUSE: stop twice, Q held
    load = 1'b1; load_val = 4'd9; step();
    start = 1'b1; step();
    step(); step(); step();
    stop = 1'b1; step();
    stop = 1'b1; step();
    chk("ab_busy", busy, 0); chk("ab_q", Q, 6);
    step();
    chk("ab_hold_q", Q, 6); chk("ab_hold_busy", busy, 0);

    // Stop in the terminal cycle -> PAUSE at Q=0, then start+stop -> IDLE
    load = 1'b1; load_val = 4'd2; step();
    start = 1'b1; step();
    step(); step();
    chk("tcs_q0", Q, 0);
    stop = 1'b1; #1;
    chk("tcs_tc", tc, 0);
    step();
    chk("tcs_busy", busy, 0); chk("tcs_q", Q, 0); chk("tcs_tc_after", tc, 0);
    start = 1'b1; stop = 1'b1; step();
    chk("ss_busy", busy, 0);
    // In IDLE with Q=0 a start is ignored (from PAUSE it would resume)
    start = 1'b1; step();
    chk("ss_idle_busy", busy, 0); chk("ss_idle_tc", tc, 0);

    // PAUSE at Q=0 then start resumes straight into the terminal cycle
    load = 1'b1; load_val = 4'd2; step();
    start = 1'b1; step();
    step(); step();
    stop = 1'b1; step();
    start = 1'b1; step();
    chk("p0_busy", busy, 1); chk("p0_tc", tc, 1); chk("p0_q", Q, 0);
    step();
    chk("p0_end_busy", busy, 0);

    // Max load: 16-cycle run
    load = 1'b1; load_val = 4'd15; step();
    chk("max_q", Q, 15);
    start = 1'b1; step();
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      step();
    end
    chk("max_run_len", cnt, 16);

    // Asynchronous reset mid-count in auto-reload
    load = 1'b1; load_val = 4'd4; auto_reload = 1'b1; step();
    start = 1'b1; step();
    step(); step();
    chk("ar_rst_q2", Q, 2);
    #3 n_reset = 1'b0;
    #1;
    chk("ar_rst_q", Q, 0); chk("ar_rst_busy", busy, 0); chk("ar_rst_tc", tc, 0);
    #1 n_reset = 1'b1;
    start = 1'b1; step();
    chk("post_rst_busy", busy, 0); chk("post_rst_q", Q, 0);
    auto_reload = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
